// File: rtl/mac_pkg.sv
// Shared types and accumulator-bound helpers for the multiply-accumulate engine.
package mac_pkg;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_mode_t;

  localparam int MAC_MAX_W = 64;

  // Largest representable accumulator value at width w (low w bits are meaningful).
  function automatic logic [MAC_MAX_W-1:0] acc_max(input int w, input bit sgn);
    if (sgn) return (64'd1 << (w - 1)) - 64'd1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Smallest representable accumulator value at width w, two's complement in the low w bits.
  function automatic logic [MAC_MAX_W-1:0] acc_min(input int w, input bit sgn);
    if (sgn) return ~((64'd1 << (w - 1)) - 64'd1);
    return '0;
  endfunction

endpackage

// File: rtl/mac_acc_if.sv
// Streaming bus of the MAC engine: operand side in, accumulator side out.
interface mac_acc_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20
);
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic             valid_in;
  logic             clear_acc;
  logic [ACC_W-1:0] f;
  logic             valid_out;
  logic             overflow;

  modport master (output a, b, valid_in, clear_acc, input f, valid_out, overflow);
  modport slave  (input a, b, valid_in, clear_acc, output f, valid_out, overflow);
endinterface

// File: rtl/mac_sat_add.sv
// Accumulate adder with overflow detection and optional clamping to the crossed bound.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic [ACC_W-1:0] base,
  input  logic [ACC_W:0]   product,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam ovf_mode_t        MODE = (SAT != 0) ? OVF_SAT : OVF_WRAP;
  localparam logic [ACC_W-1:0] HI   = ACC_W'(acc_max(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0] LO   = ACC_W'(acc_min(ACC_W, SIGNED != 0));

  logic [ACC_W:0] base_ext;
  logic [ACC_W:0] raw;

  // The extra top bit holds the true sum; signed overflow shows as disagreement with the MSB.
  always_comb begin
    base_ext = {(SIGNED != 0) ? base[ACC_W-1] : 1'b0, base};
    raw      = base_ext + product;
    ovf      = (SIGNED != 0) ? (raw[ACC_W] ^ raw[ACC_W-1]) : raw[ACC_W];
    sum      = raw[ACC_W-1:0];
    if (ovf && (MODE == OVF_SAT)) begin
      sum = ((SIGNED != 0) && raw[ACC_W]) ? LO : HI;
    end
  end

endmodule

// File: rtl/mac_acc.sv
// Multiply-accumulate engine: input register, optional product register, accumulate stage.
module mac_acc
  import mac_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int ACC_W     = 20,
  parameter int SIGNED    = 0,
  parameter int MULT_PIPE = 0,
  parameter int SAT       = 0
) (
  input  logic      clk,
  input  logic      reset,
  mac_acc_if.slave  bus
);

  localparam int PW = 2 * IN_W;

  logic [IN_W-1:0]  a_reg;
  logic [IN_W-1:0]  b_reg;
  logic             valid_s1_reg;
  logic             clear_s1_reg;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod_full;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   prod_acc;
  logic             acc_valid;
  logic             acc_clear;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [ACC_W-1:0] f_reg;
  logic             valid_out_reg;
  logic             ovf_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      valid_s1_reg <= 1'b0;
      clear_s1_reg <= 1'b0;
    end else begin
      a_reg        <= bus.a;
      b_reg        <= bus.b;
      valid_s1_reg <= bus.valid_in;
      clear_s1_reg <= bus.clear_acc;
    end
  end

  // Operands are widened to product width first so the low 2*IN_W bits are exact in either mode.
  generate
    if (SIGNED != 0) begin : g_signed
      assign a_ext    = {{IN_W{a_reg[IN_W-1]}}, a_reg};
      assign b_ext    = {{IN_W{b_reg[IN_W-1]}}, b_reg};
      assign prod_ext = {{(ACC_W + 1 - PW){prod_full[PW-1]}}, prod_full};
    end else begin : g_unsigned
      assign a_ext    = {{IN_W{1'b0}}, a_reg};
      assign b_ext    = {{IN_W{1'b0}}, b_reg};
      assign prod_ext = {{(ACC_W + 1 - PW){1'b0}}, prod_full};
    end
  endgenerate

  assign prod_full = a_ext * b_ext;

  generate
    if (MULT_PIPE != 0) begin : g_pipe
      logic [ACC_W:0] prod_s2_reg;
      logic           valid_s2_reg;
      logic           clear_s2_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prod_s2_reg  <= '0;
          valid_s2_reg <= 1'b0;
          clear_s2_reg <= 1'b0;
        end else begin
          prod_s2_reg  <= prod_ext;
          valid_s2_reg <= valid_s1_reg;
          clear_s2_reg <= clear_s1_reg;
        end
      end

      assign prod_acc  = prod_s2_reg;
      assign acc_valid = valid_s2_reg;
      assign acc_clear = clear_s2_reg;
    end else begin : g_direct
      assign prod_acc  = prod_ext;
      assign acc_valid = valid_s1_reg;
      assign acc_clear = clear_s1_reg;
    end
  endgenerate

  assign base = acc_clear ? '0 : f_reg;

  mac_sat_add #(
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_add (
    .base    (base),
    .product (prod_acc),
    .sum     (sum),
    .ovf     (add_ovf)
  );

  // A clear-bearing token restarts the sticky flag from its own add only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_reg         <= '0;
      valid_out_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      valid_out_reg <= acc_valid;
      if (acc_valid) begin
        f_reg   <= sum;
        ovf_reg <= add_ovf | (ovf_reg & ~acc_clear);
      end else if (acc_clear) begin
        f_reg   <= '0;
        ovf_reg <= 1'b0;
      end
    end
  end

  assign bus.f         = f_reg;
  assign bus.valid_out = valid_out_reg;
  assign bus.overflow  = ovf_reg;

endmodule
